// File: rtl/series_ctrl_pkg.sv
// series_ctrl_pkg
//  Shared types for the series/polynomial evaluator controller.
//  Contents:
//   state_e        controller states, 3-bit encoding
//   strobe_t       bundle of every Moore-decoded controller output strobe
//   decode_strobes maps (state, multiply-step last-cycle flag) to strobes
//  The optional abort feature (SERIES_CTRL_ABORT_EN) does not affect this file.
package series_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    INIT = 3'd2,
    MULX = 3'd3,
    MULC = 3'd4,
    ADD  = 3'd5,
    DONE = 3'd6
  } state_e;

  typedef struct packed {
    logic ldx;
    logic ldy;
    logic initr;
    logic initt;
    logic xmult;
    logic coeffmult;
    logic ldt;
    logic ldr;
    logic ready;
    logic done;
  } strobe_t;

  // Pure Moore decode: the only non-state input is the latency counter's
  // last-cycle flag, which gates ldt inside the two multiply steps.
  function automatic strobe_t decode_strobes(state_e st, logic step_last);
    strobe_t s;
    s = '0;
    case (st)
      IDLE: s.ready = 1'b1;
      LOAD: begin
        s.ldx = 1'b1;
        s.ldy = 1'b1;
      end
      INIT: begin
        s.initr = 1'b1;
        s.initt = 1'b1;
      end
      MULX: begin
        s.xmult = 1'b1;
        s.ldt   = step_last;
      end
      MULC: begin
        s.coeffmult = 1'b1;
        s.ldt       = step_last;
      end
      ADD:     s.ldr  = 1'b1;
      DONE:    s.done = 1'b1;
      default: s      = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// lat_counter
//  Counts the cycles of one multiply step and flags the last one.
//  Parameters:
//   MUL_LAT  cycles per multiply step (>= 1)
//  Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   clear   in  1  restart the count (asserted on every controller state change)
//   enable  in  1  a multiply step is in progress this cycle
//   last    out 1  this is cycle MUL_LAT of the current step
module lat_counter #(
  parameter int MUL_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] LAST_VAL = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt_reg;

  // Count runs 0..MUL_LAT-1 within a step; clear has priority so that a
  // MULX->MULC hand-over starts the second step from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign last = enable && (cnt_reg == LAST_VAL);

endmodule

// File: rtl/series_eval_ctrl.sv
// series_eval_ctrl
//  Moore FSM driving the load/init/mux strobes of the series evaluator
//  datapath (x, y, r, t registers and coefficient ROM). Runtime term count,
//  internal coefficient address counter, configurable multiply latency and a
//  one-cycle done pulse.
//  Build option: define SERIES_CTRL_ABORT_EN to add the abort port; without it
//  an evaluation always runs to DONE.
//  Parameters:
//   ADDR_W   coefficient address / nterms width (max terms 2**ADDR_W-1)
//   MUL_LAT  cycles per multiply step (>= 1)
//  Ports:
//   clk, rst          clock (rising) / asynchronous active-high reset
//   start             level: rise begins load, fall begins evaluation
//   nterms            term count, sampled while in LOAD
//   abort             cancel (only with SERIES_CTRL_ABORT_EN)
//   ldx, ldy          load x / y operand registers
//   initr, initt      initialise result / term registers
//   xmult, coeffmult  multiplier mux selects t*x / t*coeff[adr]
//   ldt               load term register (last cycle of a multiply step)
//   ldr               accumulate r <= r + t
//   adr               registered coefficient ROM address
//   ready             idle, accepting start
//   done              one-cycle result-valid pulse
module series_eval_ctrl
  import series_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] nterms,
`ifdef SERIES_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              ldx,
  output logic              ldy,
  output logic              initr,
  output logic              initt,
  output logic              xmult,
  output logic              coeffmult,
  output logic              ldt,
  output logic              ldr,
  output logic [ADDR_W-1:0] adr,
  output logic              ready,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] adr_reg;
  logic [ADDR_W-1:0] nterms_reg;
  logic              step_en;
  logic              step_clear;
  logic              step_last;
  logic              abort_hit;
  strobe_t           strobes;

`ifdef SERIES_CTRL_ABORT_EN
  assign abort_hit = abort && (state_reg != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign step_en    = (state_reg == MULX) || (state_reg == MULC);
  // Any state change restarts the step counter, so each step starts at 0.
  assign step_clear = (state_next != state_reg);

  lat_counter #(
    .MUL_LAT (MUL_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .clear  (step_clear),
    .enable (step_en),
    .last   (step_last)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start)      state_next = LOAD;
      LOAD: if (!start)     state_next = INIT;
      INIT: state_next = (nterms_reg == '0) ? DONE : MULX;
      MULX: if (step_last)  state_next = MULC;
      MULC: if (step_last)  state_next = ADD;
      // adr still holds the index of the term just accumulated.
      ADD:  state_next = (adr_reg == nterms_reg - ONE) ? DONE : MULX;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_hit) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      adr_reg    <= '0;
      nterms_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Clearing on abort makes adr read 0 on the first IDLE cycle.
      if (abort_hit || (state_reg == IDLE)) begin
        adr_reg <= '0;
      end else if (state_reg == ADD) begin
        adr_reg <= adr_reg + ONE;
      end
      if (state_reg == LOAD) begin
        nterms_reg <= nterms;
      end
    end
  end

  assign strobes   = decode_strobes(state_reg, step_last);
  assign ldx       = strobes.ldx;
  assign ldy       = strobes.ldy;
  assign initr     = strobes.initr;
  assign initt     = strobes.initt;
  assign xmult     = strobes.xmult;
  assign coeffmult = strobes.coeffmult;
  assign ldt       = strobes.ldt;
  assign ldr       = strobes.ldr;
  assign ready     = strobes.ready;
  assign done      = strobes.done;
  assign adr       = adr_reg;

endmodule

// File: tb/tb_series_eval_ctrl.sv
// tb_series_eval_ctrl
//  Two controller instances: index 0 with MUL_LAT=1, index 1 with MUL_LAT=3.
//  Stimulus pushes the expected per-run totals into a queue; a negedge
//  monitor accumulates strobe counts per instance and pops/compares when done
//  pulses. Optional abort scenario under SERIES_CTRL_ABORT_EN.
module tb_series_eval_ctrl;

  typedef struct {
    int inst;
    int n;
    int lat;
    int ldr_n;
    int ldx_n;
    int ldt_n;
    int xm_n;
    int cm_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s     [2];
  logic [3:0] nterms_s    [2];
`ifdef SERIES_CTRL_ABORT_EN
  logic       abort_s     [2];
`endif
  logic       ldx_s       [2];
  logic       ldy_s       [2];
  logic       initr_s     [2];
  logic       initt_s     [2];
  logic       xmult_s     [2];
  logic       coeffmult_s [2];
  logic       ldt_s       [2];
  logic       ldr_s       [2];
  logic       ready_s     [2];
  logic       done_s      [2];
  logic [3:0] adr_s       [2];

  exp_t exp_q[$];
  int   asserts = 0;
  int   fails   = 0;
  int   cyc     = 0;

  int c_ldx[2], c_ldr[2], c_ldt[2], c_xm[2], c_cm[2], t_init[2], xm_run[2], cm_run[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    series_eval_ctrl #(
      .ADDR_W  (4),
      .MUL_LAT ((gi == 0) ? 1 : 3)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[gi]),
      .nterms    (nterms_s[gi]),
`ifdef SERIES_CTRL_ABORT_EN
      .abort     (abort_s[gi]),
`endif
      .ldx       (ldx_s[gi]),
      .ldy       (ldy_s[gi]),
      .initr     (initr_s[gi]),
      .initt     (initt_s[gi]),
      .xmult     (xmult_s[gi]),
      .coeffmult (coeffmult_s[gi]),
      .ldt       (ldt_s[gi]),
      .ldr       (ldr_s[gi]),
      .adr       (adr_s[gi]),
      .ready     (ready_s[gi]),
      .done      (done_s[gi])
    );
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, int act, int expv);
    asserts++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        chk("onehot_state", $countones({ldx_s[i], initr_s[i], xmult_s[i], coeffmult_s[i],
                                        ldr_s[i], done_s[i], ready_s[i]}), 1);
        chk("ldx_eq_ldy", int'(ldx_s[i]), int'(ldy_s[i]));
        chk("initr_eq_initt", int'(initr_s[i]), int'(initt_s[i]));
        if (ldt_s[i]) chk("ldt_in_step", int'(xmult_s[i] | coeffmult_s[i]), 1);

        xm_run[i] = xmult_s[i] ? xm_run[i] + 1 : 0;
        cm_run[i] = coeffmult_s[i] ? cm_run[i] + 1 : 0;

        if (ready_s[i]) begin
          c_ldx[i] = 0; c_ldr[i] = 0; c_ldt[i] = 0; c_xm[i] = 0; c_cm[i] = 0;
        end
        if (ldx_s[i])       c_ldx[i]++;
        if (initr_s[i])     t_init[i] = cyc;
        if (xmult_s[i])     c_xm[i]++;
        if (coeffmult_s[i]) c_cm[i]++;
        if (ldt_s[i]) begin
          c_ldt[i]++;
          chk("ldt_last_cycle", xmult_s[i] ? xm_run[i] : cm_run[i], lat_of(i));
        end
        if (ldr_s[i]) begin
          chk("adr_at_ldr", int'(adr_s[i]), c_ldr[i]);
          c_ldr[i]++;
        end
        if (done_s[i]) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            chk("unexpected_done", int'(done_s[i]), 0);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc - t_init[i], e.lat);
            chk("ldr_count", c_ldr[i], e.ldr_n);
            chk("ldx_count", c_ldx[i], e.ldx_n);
            chk("ldt_count", c_ldt[i], e.ldt_n);
            chk("xmult_count", c_xm[i], e.xm_n);
            chk("coeffmult_count", c_cm[i], e.cm_n);
            $display("run inst=%0d mul_lat=%0d nterms=%0d latency=%0d ldr=%0d ldt=%0d",
                     i, lat_of(i), e.n, cyc - t_init[i], c_ldr[i], c_ldt[i]);
          end
        end
      end
    end
  end

  task automatic wait_idle(int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic push_exp(int i, int n, int hold);
    exp_t e;
    int   l = lat_of(i);
    e = '{i, n, 1 + n * (2 * l + 1), n, hold, 2 * n, n * l, n * l};
    exp_q.push_back(e);
  endtask

  task automatic run(int i, int n, int hold, int chg_at);
    @(negedge clk);
    start_s[i]  = 1'b1;
    nterms_s[i] = 4'(n);
    repeat (hold) @(negedge clk);
    start_s[i] = 1'b0;
    push_exp(i, n, hold);
    if (chg_at > 0) begin
      repeat (chg_at) @(negedge clk);
      nterms_s[i] = 4'd2;
    end
    wait_idle(2000);
  endtask

  task automatic check_idle(string tag, int i);
    chk({tag, "_ready"}, int'(ready_s[i]), 1);
    chk({tag, "_adr"}, int'(adr_s[i]), 0);
    chk({tag, "_strobes"}, int'({ldx_s[i], ldy_s[i], initr_s[i], initt_s[i], xmult_s[i],
                                 coeffmult_s[i], ldt_s[i], ldr_s[i], done_s[i]}), 0);
  endtask

  initial begin
    int k;
    int cnt;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      nterms_s[i] = 4'd0;
`ifdef SERIES_CTRL_ABORT_EN
      abort_s[i]  = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    check_idle("reset", 0);
    check_idle("reset", 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 3, 2, 0);    // MUL_LAT=1: latency 10, ldx 2 cycles
    run(1, 2, 1, 0);    // MUL_LAT=3: latency 15
    run(0, 0, 1, 0);    // zero terms: latency 1, no multiply activity
    run(0, 15, 3, 5);   // full range, nterms changed mid-run ignored
    run(1, 1, 4, 0);    // MUL_LAT=3: latency 8
    run(1, 0, 2, 0);    // zero terms on slow instance

    // Reset during the second MULC step
    @(negedge clk);
    start_s[1]  = 1'b1;
    nterms_s[1] = 4'd4;
    @(negedge clk);
    start_s[1] = 1'b0;
    push_exp(1, 4, 1);
    k = 0;
    while (!(coeffmult_s[1] && adr_s[1] == 4'd1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("reach_mulc", int'(coeffmult_s[1] && adr_s[1] == 4'd1), 1);
    rst = 1'b1;
    #1;
    check_idle("mid_rst", 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check_idle("post_rst", 1);

`ifdef SERIES_CTRL_ABORT_EN
    // Abort during the second ADD of a 4-term run
    @(negedge clk);
    start_s[0]  = 1'b1;
    nterms_s[0] = 4'd4;
    @(negedge clk);
    start_s[0] = 1'b0;
    push_exp(0, 4, 1);
    cnt = 0;
    k   = 0;
    while (cnt < 2 && k < 400) begin
      @(negedge clk);
      k++;
      if (ldr_s[0]) cnt++;
    end
    chk("reach_add2", cnt, 2);
    abort_s[0] = 1'b1;
    @(posedge clk);
    #1;
    check_idle("abort", 0);
    abort_s[0] = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
`else
    cnt = 0;
`endif

    run(0, 2, 1, 0);    // recovery after reset / abort
    run(1, 3, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
